// File: rtl/axi_pkg.sv
// Shared AXI definitions for the slave-side channel controllers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: burst type encoding, response codes, write-controller FSM states.
package axi_pkg;

    // AWBURST / ARBURST encoding
    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    // BRESP / RRESP encoding
    typedef logic [1:0] resp_t;
    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;

    // Write controller sequencing: address, data beats, response
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_t;

endpackage : axi_pkg

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts plus an illegal-burst flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to consume next_addr.
//
// Ports:
//   addr      current beat address
//   size      log2(bytes per beat)
//   len       beats minus 1
//   burst     burst type (burst_t encoding)
//   next_addr address of the following beat
//   illegal   burst cannot be serviced (oversize beat, reserved type,
//             bad WRAP length or misaligned WRAP start)
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [3:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  illegal
);

    localparam int MAX_SIZE = $clog2(STRB_WIDTH);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic                  len_ok;
    logic                  aligned;

    always_comb begin
        bytes     = ADDR_WIDTH'(1) << size;
        // Wrap window is (len+1)*bytes; len_ok guarantees a power of two.
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        incr_addr = addr + bytes;
        aligned   = ((addr & (bytes - ADDR_WIDTH'(1))) == '0);
        len_ok    = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);

        next_addr = addr;
        illegal   = (int'(size) > MAX_SIZE);

        case (burst_t'(burst))
            FIXED: next_addr = addr;
            INCR:  next_addr = incr_addr;
            WRAP: begin
                next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                if (!len_ok || !aligned) begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule : axi_burst_addr_gen

// File: rtl/axi_slave_wr_ctrl.sv
// AXI slave write controller: one burst at a time from AW/W onto a memory write port, B response back.
// Latency: W handshake at t gives mem_we at t+1; last beat gives bvalid at t+1; awready returns 2 cycles after B handshake.
// Backpressure: awready only in IDLE, wready only in DATA, bvalid held until bready; one outstanding burst.
//
// Ports:
//   aclk, arst                  clock, asynchronous active-low reset
//   aw*                         write address channel (id, addr, len, size, burst, handshake)
//   w*                          write data channel (id, data, strobes, last, handshake)
//   b*                          write response channel (id, resp, handshake)
//   mem_we/addr/wdata/wstrb     single-cycle memory write strobe and beat payload
module axi_slave_wr_ctrl
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8
) (
    input  logic                  aclk,
    input  logic                  arst,
    // write address channel
    input  logic [3:0]            awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    // write data channel
    input  logic [3:0]            wid,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    // write response channel
    output logic [3:0]            bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    // memory write port
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb
);

    wr_state_t             state;

    // Captured burst attributes
    logic [3:0]            cap_id;
    logic [3:0]            cap_len;
    logic [2:0]            cap_size;
    logic [1:0]            cap_burst;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [3:0]            beat_cnt;
    logic                  err;        // sticky: burst will answer SLVERR
    logic                  burst_bad;  // whole burst unserviceable, no memory writes

    // Address generator inputs: in IDLE it examines the incoming AW so the
    // illegal flag is ready at capture; afterwards it walks the captured burst.
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic [2:0]            gen_size;
    logic [3:0]            gen_len;
    logic [1:0]            gen_burst;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  illegal;

    always_comb begin
        if (state == IDLE) begin
            gen_addr  = awaddr;
            gen_size  = awsize;
            gen_len   = awlen;
            gen_burst = awburst;
        end else begin
            gen_addr  = cur_addr;
            gen_size  = cap_size;
            gen_len   = cap_len;
            gen_burst = cap_burst;
        end
    end

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_addr_gen (
        .addr      (gen_addr),
        .size      (gen_size),
        .len       (gen_len),
        .burst     (gen_burst),
        .next_addr (next_addr),
        .illegal   (illegal)
    );

    // Per-beat protocol checks
    logic w_hs;
    logic cnt_last;
    logic beat_last;
    logic beat_err;
    logic id_bad;

    always_comb begin
        w_hs      = wvalid && wready;
        cnt_last  = (beat_cnt == cap_len);
        id_bad    = (wid != cap_id);
        // Either counter exhaustion or wlast ends the burst; a disagreement
        // between the two (early wlast or missing wlast) is an error.
        beat_last = cnt_last || wlast;
        beat_err  = (cnt_last != wlast) || id_bad;
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state     <= IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= OKAY;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            cap_id    <= '0;
            cap_len   <= '0;
            cap_size  <= '0;
            cap_burst <= '0;
            cur_addr  <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            burst_bad <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    // awready is raised one cycle after entering IDLE, so
                    // an AW is never accepted in the same cycle as B.
                    if (!awready) begin
                        awready <= 1'b1;
                    end else if (awvalid) begin
                        cap_id    <= awid;
                        cap_len   <= awlen;
                        cap_size  <= awsize;
                        cap_burst <= awburst;
                        cur_addr  <= awaddr;
                        beat_cnt  <= '0;
                        err       <= illegal;
                        burst_bad <= illegal;
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (w_hs) begin
                        mem_we    <= !burst_bad && !id_bad;
                        mem_addr  <= cur_addr;
                        mem_wdata <= wdata;
                        mem_wstrb <= wstrb;
                        cur_addr  <= next_addr;
                        beat_cnt  <= beat_cnt + 4'd1;
                        err       <= err || beat_err;
                        if (beat_last) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= cap_id;
                            bresp  <= (err || beat_err) ? SLVERR : OKAY;
                            state  <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    awready <= 1'b0;
                    wready  <= 1'b0;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule : axi_slave_wr_ctrl

// File: tb/tb_axi_slave_wr_ctrl.sv
// Directed bench for axi_slave_wr_ctrl: drives AW/W/B, records memory writes,
// compares against hand-computed burst addresses, responses and timing.
module tb_axi_slave_wr_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW/8;

    logic          aclk = 1'b0;
    logic          arst = 1'b1;
    logic [3:0]    awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [3:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [3:0]    wid = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [3:0]    bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    logic [SW-1:0] wq_strb[$];

    axi_slave_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb)
    );

    always #5 aclk = ~aclk;

    // mem_we is a full-cycle pulse, so sampling on the falling edge sees it once
    always @(negedge aclk) begin
        if (mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_strb.push_back(mem_wstrb);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] base, input int i);
        return 32'hD000_0000 | (32'(base[15:0]) << 8) | 32'(i);
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int i);
        return (i % 2 == 1) ? 4'h3 : 4'hF;
    endfunction

    // All drivers are entered and left on a falling edge.
    task automatic send_aw(input logic [3:0] id, input logic [AW-1:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        while (!awready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!awready) chk("aw_timeout", 64'(awready), 64'd1);
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic last);
        int n = 0;
        wid = id; wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!wready) chk("w_timeout", 64'(wready), 64'd1);
        @(negedge aclk);
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    // Waits for B, holds bready low for 'hold' cycles, then completes the
    // handshake and checks awready comes back exactly one cycle later.
    task automatic wait_b(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int hold);
        int n = 0;
        while (!bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("bvalid", 64'(bvalid), 64'd1);
        chk("bid", 64'(bid), 64'(exp_id));
        chk("bresp", 64'(bresp), 64'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            chk("bvalid_hold", 64'(bvalid), 64'd1);
            chk("bid_hold", 64'(bid), 64'(exp_id));
            chk("awready_hold", 64'(awready), 64'd0);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_drop", 64'(bvalid), 64'd0);
        chk("awready_b+1", 64'(awready), 64'd0);
        @(negedge aclk);
        chk("awready_b+2", 64'(awready), 64'd1);
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [AW-1:0] addr,
                             input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int nbeats,
                             input int last_idx, input int bad_idx);
        wq_addr.delete(); wq_data.delete(); wq_strb.delete();
        send_aw(id, addr, len, size, burst);
        for (int i = 0; i < nbeats; i++) begin
            send_w((i == bad_idx) ? id + 4'd1 : id, beat_data(addr, i),
                   beat_strb(i), i == last_idx);
        end
    endtask

    task automatic check_wr(input string tag, input int k, input logic [AW-1:0] exp_addr,
                            input logic [AW-1:0] base, input int beat);
        if (k < wq_addr.size()) begin
            chk({tag, "_addr"}, 64'(wq_addr[k]), 64'(exp_addr));
            chk({tag, "_data"}, 64'(wq_data[k]), 64'(beat_data(base, beat)));
            chk({tag, "_strb"}, 64'(wq_strb[k]), 64'(beat_strb(beat)));
        end else begin
            chk({tag, "_missing"}, 64'(wq_addr.size()), 64'(k + 1));
        end
    endtask

    initial begin
        // Reset state
        #1 arst = 1'b0;
        #1;
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_bid_bresp", 64'({bid, bresp}), 64'd0);
        repeat (2) @(negedge aclk);
        arst = 1'b1;
        @(negedge aclk);
        chk("post_rst_awready", 64'(awready), 64'd1);
        chk("post_rst_wready", 64'(wready), 64'd0);

        // Minimum latency, awlen=0
        wq_addr.delete(); wq_data.delete(); wq_strb.delete();
        send_aw(4'd2, 32'h40, 4'd0, 3'd2, 2'b01);
        chk("lat_wready", 64'(wready), 64'd1);
        chk("lat_awready", 64'(awready), 64'd0);
        send_w(4'd2, beat_data(32'h40, 0), beat_strb(0), 1'b1);
        chk("lat_mem_we", 64'(mem_we), 64'd1);
        chk("lat_bvalid", 64'(bvalid), 64'd1);
        chk("lat_wready_drop", 64'(wready), 64'd0);
        wait_b(4'd2, 2'b00, 0);
        chk("lat_nwr", 64'(wq_addr.size()), 64'd1);
        check_wr("lat_w0", 0, 32'h40, 32'h40, 0);

        // INCR 4 beats
        run_burst(4'd5, 32'h100, 4'd3, 3'd2, 2'b01, 4, 3, -1);
        wait_b(4'd5, 2'b00, 0);
        chk("incr_nwr", 64'(wq_addr.size()), 64'd4);
        check_wr("incr_w0", 0, 32'h100, 32'h100, 0);
        check_wr("incr_w1", 1, 32'h104, 32'h100, 1);
        check_wr("incr_w2", 2, 32'h108, 32'h100, 2);
        check_wr("incr_w3", 3, 32'h10C, 32'h100, 3);

        // WRAP 4 beats across a 16-byte window
        run_burst(4'd1, 32'h38, 4'd3, 3'd2, 2'b10, 4, 3, -1);
        wait_b(4'd1, 2'b00, 0);
        chk("wrap_nwr", 64'(wq_addr.size()), 64'd4);
        check_wr("wrap_w0", 0, 32'h38, 32'h38, 0);
        check_wr("wrap_w1", 1, 32'h3C, 32'h38, 1);
        check_wr("wrap_w2", 2, 32'h30, 32'h38, 2);
        check_wr("wrap_w3", 3, 32'h34, 32'h38, 3);

        // FIXED 3 beats with B stalled for 5 cycles
        run_burst(4'd9, 32'h20, 4'd2, 3'd2, 2'b00, 3, 2, -1);
        wait_b(4'd9, 2'b00, 5);
        chk("fixed_nwr", 64'(wq_addr.size()), 64'd3);
        check_wr("fixed_w0", 0, 32'h20, 32'h20, 0);
        check_wr("fixed_w1", 1, 32'h20, 32'h20, 1);
        check_wr("fixed_w2", 2, 32'h20, 32'h20, 2);

        // Early wlast on beat 1 of a 4-beat burst
        run_burst(4'd4, 32'h80, 4'd3, 3'd2, 2'b01, 2, 1, -1);
        chk("early_wready", 64'(wready), 64'd0);
        wait_b(4'd4, 2'b10, 0);
        chk("early_nwr", 64'(wq_addr.size()), 64'd2);
        check_wr("early_w1", 1, 32'h84, 32'h80, 1);

        // Missing wlast on a 2-beat burst
        run_burst(4'd6, 32'h90, 4'd1, 3'd2, 2'b01, 2, -1, -1);
        wait_b(4'd6, 2'b10, 0);
        chk("miss_nwr", 64'(wq_addr.size()), 64'd2);
        check_wr("miss_w1", 1, 32'h94, 32'h90, 1);

        // Reserved burst type: beats accepted, nothing written
        run_burst(4'd7, 32'h50, 4'd1, 3'd2, 2'b11, 2, 1, -1);
        wait_b(4'd7, 2'b10, 0);
        chk("rsvd_nwr", 64'(wq_addr.size()), 64'd0);

        // Beat wider than the data bus
        run_burst(4'd8, 32'h60, 4'd0, 3'd3, 2'b01, 1, 0, -1);
        wait_b(4'd8, 2'b10, 0);
        chk("size_nwr", 64'(wq_addr.size()), 64'd0);

        // WID mismatch on beat 1 of 3
        run_burst(4'd3, 32'hA0, 4'd2, 3'd2, 2'b01, 3, 2, 1);
        wait_b(4'd3, 2'b10, 0);
        chk("wid_nwr", 64'(wq_addr.size()), 64'd2);
        check_wr("wid_w0", 0, 32'hA0, 32'hA0, 0);
        check_wr("wid_w1", 1, 32'hA8, 32'hA0, 2);

        // Reset during beat 2 of an 8-beat burst
        run_burst(4'd7, 32'h200, 4'd7, 3'd2, 2'b01, 2, -1, -1);
        wid = 4'd7; wdata = beat_data(32'h200, 2); wstrb = beat_strb(2); wvalid = 1'b1;
        #2 arst = 1'b0;
        #1;
        chk("mid_rst_awready", 64'(awready), 64'd0);
        chk("mid_rst_wready", 64'(wready), 64'd0);
        chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
        chk("mid_rst_mem_we", 64'(mem_we), 64'd0);
        chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("mid_rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("mid_rst_bid_bresp", 64'({bid, bresp}), 64'd0);
        wvalid = 1'b0;
        @(negedge aclk);
        arst = 1'b1;
        @(negedge aclk);
        chk("rel_awready", 64'(awready), 64'd1);
        chk("rel_bvalid", 64'(bvalid), 64'd0);
        run_burst(4'd6, 32'hC0, 4'd1, 3'd2, 2'b01, 2, 1, -1);
        wait_b(4'd6, 2'b00, 0);
        chk("rel_nwr", 64'(wq_addr.size()), 64'd2);
        check_wr("rel_w0", 0, 32'hC0, 32'hC0, 0);
        check_wr("rel_w1", 1, 32'hC4, 32'hC0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axi_slave_wr_ctrl

// File: doc/axi_slave_wr_ctrl.md
Name: axi_slave_wr_ctrl

Overview:
Slave-side write-channel controller for the AXI interface. It accepts one write burst at a time on the AW/W/B channels and sequences it onto a simple single-port memory write port. It generates per-beat addresses for FIXED, INCR and WRAP bursts, checks burst protocol, and returns the B response. It sits between the interface's slave side and the testbench/DUT memory model.

Parameters:
ADDR_WIDTH, 32, address width; must equal the interface `addr_width.
DATA_WIDTH, 32, data width in bits (32/64/128); must equal `data_width.
STRB_WIDTH, DATA_WIDTH/8, write-strobe width; derived, do not override.

Ports:
aclk  in  1  clock; all logic on posedge.
arst  in  1  asynchronous, active-low reset.
awid  in  4  write address ID.
awaddr  in  ADDR_WIDTH  burst start address.
awlen  in  4  beats minus 1.
awsize  in  3  log2 bytes per beat.
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
awvalid  in  1  AW valid.
awready  out  1  AW ready.
wid  in  4  write data ID.
wdata  in  DATA_WIDTH  write data.
wstrb  in  STRB_WIDTH  byte strobes.
wlast  in  1  last beat flag.
wvalid  in  1  W valid.
wready  out  1  W ready.
bid  out  4  response ID.
bresp  out  2  00 OKAY, 10 SLVERR.
bvalid  out  1  B valid.
bready  in  1  B ready.
mem_we  out  1  one-cycle memory write strobe.
mem_addr  out  ADDR_WIDTH  beat address.
mem_wdata  out  DATA_WIDTH  beat data.
mem_wstrb  out  STRB_WIDTH  beat byte enables.

Behaviour:
- Reset (arst=0, async): state IDLE; awready, wready, bvalid, mem_we = 0; bid, bresp, mem_addr, mem_wdata, mem_wstrb = 0; beat counter and error flag cleared. Reset mid-burst discards the burst; no B is issued.
- All outputs are registered.
- FSM IDLE -> DATA -> RESP -> IDLE.
- IDLE: awready=1 starting the first cycle after reset release. On awvalid&&awready, capture awid/awaddr/awlen/awsize/awburst, clear the beat counter, drop awready and go to DATA. wready=1 on the next cycle.
- DATA: wready=1. On each wvalid&&wready at cycle t:
  - mem_we=1 at t+1 with the current mem_addr, wdata and wstrb.
  - The address then advances for the next beat.
  - The beat counter increments.
- Burst end: the beat is the last one if beat_cnt==awlen or wlast=1. On a last-beat handshake, wready drops, the FSM goes to RESP, and bvalid=1 at t+1.
- RESP: bvalid holds with bid=captured awid until bready. On bvalid&&bready, bvalid drops and awready rises the following cycle. bvalid never deasserts without bready.
- Address generation, with bytes = 1<<awsize:
  - FIXED: address constant.
  - INCR: address += bytes, modulo 2^ADDR_WIDTH.
  - WRAP: boundary = (awlen+1)*bytes. Next address = (addr & ~(boundary-1)) | ((addr+bytes) & (boundary-1)).
- Error detection. Any error sets sticky bresp=SLVERR for the burst. Beats are still accepted to keep the bus live.
  - wlast=1 with beat_cnt<awlen: early end; burst terminates on that beat.
  - beat_cnt==awlen with wlast=0: missing last; burst terminates anyway.
  - wid != captured awid: that beat is accepted but mem_we is suppressed.
  - awsize > log2(STRB_WIDTH), awburst==11, WRAP with awlen not in {1,3,7,15}, or WRAP start not aligned to bytes: all beats accepted, no mem_we for the whole burst.
- Simultaneous events: awvalid during DATA/RESP is not accepted (awready=0). W beats arriving before AW are not accepted (wready=0 in IDLE). One outstanding burst only.
- Minimum latency for an awlen=0 burst:
  - AW handshake at T; W handshake at T+1.
  - mem_we and bvalid both at T+2.
  - With bready=1, awready returns at T+4.

Decomposition:
- Shared package axi_pkg holds:
  - typedef burst_t enum {FIXED, INCR, WRAP, RSVD}.
  - resp_t constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - typedef wr_state_t {IDLE, DATA, RESP}.
- One sub-module, axi_burst_addr_gen: combinational next-address from addr/size/len/burst, plus an illegal-burst flag. Shared later with the read controller.

Test Plan:
- INCR, awaddr=0x100, awlen=3, awsize=2, wid=awid=5, correct wlast on beat 3 -> mem_we at 0x100, 0x104, 0x108, 0x10C; bid=5, bresp=00.
- WRAP, awaddr=0x38, awlen=3, awsize=2 -> mem_addr 0x38, 0x3C, 0x30, 0x34; bresp=00.
- FIXED, awaddr=0x20, awlen=2, bready held 0 for 5 cycles -> three writes to 0x20; bvalid stays 1 and stable; awready=0 until 1 cycle after the bready handshake.
- INCR awlen=3 with wlast on beat 1 -> 2 writes; burst ends; bresp=10. Second case: awlen=1 without wlast -> 2 writes, bresp=10.
- awburst=11 (or awsize=3 with DATA_WIDTH=32) -> awlen+1 beats accepted, zero mem_we, bresp=10. Beat with wid≠awid -> that beat not written, bresp=10.
- Drive arst=0 during beat 2 of an awlen=7 burst -> all outputs 0 immediately. After release: awready=1, no bvalid, and a new burst completes OKAY.
